// File: rtl/kernel_attention_score_accum.sv
// kernel_attention_score_accum
// Sums one row of unsigned products (one Q.K dot product) and scales the sum
// by a right shift. It then saturates the result and queues it, tagged with a
// row index and a beat count, in a 2-entry FIFO for the softmax stage.
module kernel_attention_score_accum #(
    parameter int PROD_WIDTH = 16,
    parameter int MAX_LEN    = 64,
    parameter int LEN_WIDTH  = 7,
    parameter int ACC_WIDTH  = 22,
    parameter int SHIFT      = 3,
    parameter int OUT_WIDTH  = 16,
    parameter int ROW_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [ROW_WIDTH-1:0]  out_row,
    output logic [LEN_WIDTH-1:0]  out_len,
    output logic                  len_err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam logic [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [ROW_WIDTH-1:0]   r_row;
    logic                   r_len_err;

    logic [OUT_WIDTH-1:0]   r_mem_data [2];
    logic [ROW_WIDTH-1:0]   r_mem_row  [2];
    logic [LEN_WIDTH-1:0]   r_mem_len  [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic [OUT_WIDTH-1:0]   r_hold_data;
    logic [ROW_WIDTH-1:0]   r_hold_row;
    logic [LEN_WIDTH-1:0]   r_hold_len;

    logic                   w_accept;
    logic                   w_first;
    logic [LEN_WIDTH-1:0]   w_cnt_inc;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic [ACC_WIDTH-1:0]   w_scaled;
    logic [OUT_WIDTH-1:0]   w_sat;
    logic                   w_close;
    logic                   w_force;
    logic                   w_push;
    logic                   w_pop;

    // Ready depends only on the FIFO fill state; held low while in reset
    assign in_ready  = !reset && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign len_err   = r_len_err;

    // Empty FIFO shows the last popped head, so outputs hold after a drain
    assign out_data = out_valid ? r_mem_data[r_rd_ptr] : r_hold_data;
    assign out_row  = out_valid ? r_mem_row[r_rd_ptr]  : r_hold_row;
    assign out_len  = out_valid ? r_mem_len[r_rd_ptr]  : r_hold_len;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, running sum, row close detection and saturation
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = in_valid && in_ready;
        w_first     = (r_state == ST_IDLE);
        w_cnt_inc   = w_first ? LEN_WIDTH'(1) : r_cnt + 1'b1;
        w_sum       = (w_first ? '0 : r_acc) + ACC_WIDTH'(in_prod);
        w_close     = w_accept && (in_last || (w_cnt_inc == LEN_WIDTH'(MAX_LEN)));
        w_force     = w_close && !in_last;
        w_push      = w_close;
        w_scaled    = w_sum >> SHIFT;
        w_sat       = (w_scaled > SAT_MAX) ? '1 : w_scaled[OUT_WIDTH-1:0];
        if (w_accept)
            w_state_nxt = w_close ? ST_IDLE : ST_ACCUM;
    end

    // Accumulator and beat counter; cleared when a row closes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Sticky overlength flag, set when a row is force-closed at MAX_LEN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_len_err <= 1'b0;
        else if (w_force) r_len_err <= 1'b1;
    end

    // Result FIFO storage, pointers, fill count and row counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem_data[i] <= '0;
                r_mem_row[i]  <= '0;
                r_mem_len[i]  <= '0;
            end
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
            r_row       <= '0;
            r_hold_data <= '0;
            r_hold_row  <= '0;
            r_hold_len  <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_sat;
                r_mem_row[r_wr_ptr]  <= r_row;
                r_mem_len[r_wr_ptr]  <= w_cnt_inc;
                r_wr_ptr             <= ~r_wr_ptr;
                r_row                <= r_row + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_hold_data <= r_mem_data[r_rd_ptr];
                r_hold_row  <= r_mem_row[r_rd_ptr];
                r_hold_len  <= r_mem_len[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
